proc_ctrl: RTL

Control unit for the 9-bit bus-based processor. It sequences the shared datapath of eight general registers R0–R7, accumulator A, result register G, instruction register IR, the add/sub unit and the 9-bit bus. It decodes the instruction held in IR and drives every load enable and bus-driver select through a 4-step (T0–T3) state machine. It signals Done on the last step of each instruction and guarantees at most one bus driver per cycle.

---
 rtl/proc_ctrl_if.sv | 25 ++
 rtl/proc_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/proc_ctrl_if.sv
// proc_ctrl_if: instruction/status inputs and datapath control outputs of the processor control unit
interface proc_ctrl_if;
  logic       Run;
  logic [8:0] IR;
  logic       Gnz;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;
  logic       Illegal;
  logic [1:0] Tstep;
  modport master (
    input  Run, IR, Gnz,
    output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Tstep
  );
  modport slave (
    output Run, IR, Gnz,
    input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Tstep
  );
endinterface

// File: rtl/proc_ctrl.sv
// proc_ctrl: T0-T3 sequencer decoding IR into register load enables and a single bus driver per cycle
module proc_ctrl #(
  parameter bit HAS_MVNZ = 1'b1
) (
  input logic        Clock,
  input logic        Reset,
  proc_ctrl_if.master bus
);
  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;
  tstep_t tstep_q, tstep_d;
  logic [2:0] op;
  logic [7:0] xr, yr;
  assign op        = bus.IR[8:6];
  assign xr        = 8'b1 << bus.IR[5:3];
  assign yr        = 8'b1 << bus.IR[2:0];
  assign bus.Tstep = tstep_q;
  // step register; reset always returns to T0 and beats a simultaneous Run
  always_ff @(posedge Clock)
    tstep_q <= Reset ? T0 : tstep_d;
  // decode step and opcode into enables; everything held low during reset
  always_comb begin
    tstep_d     = tstep_q;
    bus.IRin    = 1'b0;
    bus.Rin     = '0;
    bus.Rout    = '0;
    bus.DINout  = 1'b0;
    bus.Gout    = 1'b0;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.AddSub  = 1'b0;
    bus.Done    = 1'b0;
    bus.Illegal = 1'b0;
    if (!Reset) begin
      case (tstep_q)
        T0: begin
          bus.IRin = bus.Run;
          tstep_d  = bus.Run ? T1 : T0;
        end
        T1: begin
          tstep_d  = T0;
          bus.Done = 1'b1;
          case (op)
            3'b000: begin
              bus.Rout = yr;
              bus.Rin  = xr;
            end
            3'b001: begin
              bus.DINout = 1'b1;
              bus.Rin    = xr;
            end
            3'b010, 3'b011: begin
              bus.Rout = xr;
              bus.Ain  = 1'b1;
              bus.Done = 1'b0;
              tstep_d  = T2;
            end
            3'b100: begin
              bus.Rout    = (HAS_MVNZ && bus.Gnz) ? yr : '0;
              bus.Rin     = (HAS_MVNZ && bus.Gnz) ? xr : '0;
              bus.Illegal = !HAS_MVNZ;
            end
            default: bus.Illegal = 1'b1;
          endcase
        end
        T2: begin
          bus.Rout   = yr;
          bus.Gin    = 1'b1;
          bus.AddSub = op[0];
          tstep_d    = T3;
        end
        T3: begin
          bus.Gout = 1'b1;
          bus.Rin  = xr;
          bus.Done = 1'b1;
          tstep_d  = T0;
        end
      endcase
    end
  end
endmodule
